pcs_link_controller: RTL and testbench
======================================

# pcs_link_controller

Link bring-up and supervision controller for the 1000BASE-X PCS receive path. Sequences power-up and reset of the Synchronization block by driving its `mr_main_reset` and `power_on` inputs, then monitors `code_sync_status`. It declares link after a stable-sync qualification period, retries bring-up on timeout, and counts sync losses. It sits between management and the Synchronization instance; its `rx_enable` gates the downstream receive state machine.

## Interface
- `RESET_CYCLES`, 4: cycles `pcs_reset` is held in PCS_RESET (≥1).
- `LINK_TIMER`, 16: consecutive sync-high cycles required before link (≥1).
- `SYNC_TIMEOUT`, 64: cycles allowed in WAIT_SYNC before a retry (≥1).
- `RETRY_LIMIT`, 3: total bring-up attempts before FAIL (≥1).

Ports:
- `Clk`  in  1  single clock; all logic on rising edge.
- `mr_main_reset`  in  1  reset, synchronous and active-high.
- `mr_restart`  in  1  management restart request, level-sampled.
- `code_sync_status`  in  1  from Synchronization.
- `pcs_reset`  out  1  drives Synchronization `mr_main_reset`.
- `power_on`  out  1  drives Synchronization `power_on`.
- `link_up`  out  1  link qualified.
- `rx_enable`  out  1  enables downstream receive; equals `link_up`.
- `retry_fail`  out  1  bring-up exhausted.
- `sync_loss_count`  out  8  saturating count of sync losses while linked.
- `state`  out  3  current state encoding (debug).

## Operation
- Moore FSM. Outputs decode from registered state only; no input-to-output combinational path.
- States and outputs:
  - POWER_UP: `power_on`=1, `pcs_reset`=1.
  - PCS_RESET: `pcs_reset`=1.
  - WAIT_SYNC: no outputs asserted.
  - CONFIRM: no outputs asserted.
  - LINK_OK: `link_up`=`rx_enable`=1.
  - FAIL: `pcs_reset`=1, `retry_fail`=1.
- Transitions:
  - POWER_UP→PCS_RESET unconditionally.
  - PCS_RESET→WAIT_SYNC after RESET_CYCLES cycles.
  - WAIT_SYNC→CONFIRM on `code_sync_status`=1. On timeout (SYNC_TIMEOUT cycles with sync low), increment the attempt count. Go to FAIL if the attempt count reaches RETRY_LIMIT, otherwise to PCS_RESET.
  - CONFIRM→LINK_OK when sync has been high for LINK_TIMER consecutive cycles. Any low sample returns to WAIT_SYNC: timer cleared, attempt count unchanged, not counted as a loss.
  - LINK_OK→WAIT_SYNC on sync low. `sync_loss_count` increments, saturating at 255.
  - FAIL is held until `mr_restart` or reset.
- One shared cycle timer is cleared on every state entry.
- The attempt counter clears on LINK_OK entry and on `mr_restart`.
- Priority: `mr_main_reset` > `mr_restart` > FSM transitions.
- `mr_restart`=1 in any state goes to PCS_RESET next cycle. It clears the attempt counter and leaves `sync_loss_count` unchanged. Held high, it keeps re-entering PCS_RESET.
- `mr_main_reset`=1 goes to POWER_UP and zeroes all counters.
- Timer width: $clog2(max(RESET_CYCLES, LINK_TIMER, SYNC_TIMEOUT)+1).

## Timing
- Reset values: state=POWER_UP, `power_on`=1, `pcs_reset`=1, `link_up`=`rx_enable`=`retry_fail`=0, `sync_loss_count`=0.
- First edge with reset low enters PCS_RESET. `pcs_reset` falls after edge RESET_CYCLES counted from that edge.
- Sync first sampled high in WAIT_SYNC → `link_up` rises 1+LINK_TIMER edges later.
- Sync low sampled in LINK_OK → `link_up` low and count incremented on the next edge.
- Failed attempt duration: RESET_CYCLES+SYNC_TIMEOUT cycles.

## Structure
- Shared header holds state encodings:
  - POWER_UP=0, PCS_RESET=1, WAIT_SYNC=2, CONFIRM=3, LINK_OK=4, FAIL=5.
- Shared header also holds the default parameter constants.
- Sub-module `ctrl_timer`: parameterised up-counter with `clear`, `enable`, `terminal` compare input, and `done` output.

## Test plan
Defaults assumed.
- Release reset; assert sync on WAIT_SYNC entry and hold → `pcs_reset` low 4 edges after release; `link_up`=1 exactly 17 edges after sync first sampled; `state`=4.
- Sync drops at CONFIRM cycle 10 for 1 cycle, then rises again → back to WAIT_SYNC; `link_up` stays 0; `sync_loss_count`=0; full 16-cycle requalification required.
- In LINK_OK, pulse sync low → `link_up`=0 next edge and count=1. Repeat 300 losses → count saturates at 255.
- Sync held low → 3 attempts of 68 cycles; `retry_fail`=1 and `pcs_reset`=1 at edge 204 after release; state remains FAIL indefinitely.
- `mr_restart` pulse in FAIL → `retry_fail`=0, PCS_RESET for 4 cycles, then WAIT_SYNC. Pulse in LINK_OK → `link_up`=0 next edge; `sync_loss_count` unchanged.
- `mr_main_reset` and `mr_restart` together mid-CONFIRM → POWER_UP, all outputs at reset values, counters zero.

Source files
------------

// File: rtl/pcs_link_controller_pkg.sv
// rtl/pcs_link_controller_pkg.sv - shared state encodings and default timing constants
// Purpose: state encodings and default parameter values used by the link
// controller, plus a small constant helper used to size the shared timer.
// Ports: none (package).

package pcs_link_controller_pkg;

    typedef enum logic [2:0] {
        ST_POWER_UP  = 3'd0,
        ST_PCS_RESET = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_CONFIRM   = 3'd3,
        ST_LINK_OK   = 3'd4,
        ST_FAIL      = 3'd5
    } link_state_e;

    localparam int DEF_RESET_CYCLES = 4;
    localparam int DEF_LINK_TIMER   = 16;
    localparam int DEF_SYNC_TIMEOUT = 64;
    localparam int DEF_RETRY_LIMIT  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ctrl_timer.sv
// rtl/ctrl_timer.sv - clearable up-counter with terminal compare
// Purpose: cycle timer shared by all timed controller states.
// Ports:
//   clk      in          clock, rising edge
//   rst      in          synchronous active-high reset
//   clear    in          zero the count on the next edge (wins over enable)
//   enable   in          advance the count by one
//   terminal in  [W-1:0] compare value
//   done     out         count equals terminal

module ctrl_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            // Saturate rather than wrap so a stalled state can never alias
            // back onto a small terminal value.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == terminal);

endmodule

// File: rtl/pcs_link_controller.sv
// rtl/pcs_link_controller.sv - 1000BASE-X PCS receive link bring-up and supervision FSM
// Purpose: powers up and resets the Synchronization block, waits for code
// sync, qualifies it for a stable period, declares link, retries bring-up on
// timeout and counts sync losses while linked.
// Ports:
//   Clk              in      clock, rising edge
//   mr_main_reset    in      synchronous active-high reset
//   mr_restart       in      management restart, level-sampled
//   code_sync_status in      sync indication from Synchronization
//   pcs_reset        out     Synchronization mr_main_reset
//   power_on         out     Synchronization power_on
//   link_up          out     link qualified
//   rx_enable        out     downstream receive enable (same as link_up)
//   retry_fail       out     bring-up attempts exhausted
//   sync_loss_count  out [8] saturating count of losses while linked
//   state            out [3] current state encoding

module pcs_link_controller
    import pcs_link_controller_pkg::*;
#(
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int LINK_TIMER   = DEF_LINK_TIMER,
    parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int RETRY_LIMIT  = DEF_RETRY_LIMIT
) (
    input  logic       Clk,
    input  logic       mr_main_reset,
    input  logic       mr_restart,
    input  logic       code_sync_status,
    output logic       pcs_reset,
    output logic       power_on,
    output logic       link_up,
    output logic       rx_enable,
    output logic       retry_fail,
    output logic [7:0] sync_loss_count,
    output logic [2:0] state
);

    localparam int TW = $clog2(max3(RESET_CYCLES, LINK_TIMER, SYNC_TIMEOUT) + 1);
    localparam int AW = $clog2(RETRY_LIMIT + 1);

    // The timer reads 0 in the first cycle of a state, so a state lasting N
    // cycles exits when the count reaches N-1. CONFIRM exits at LINK_TIMER
    // because the sync sample that entered CONFIRM plus LINK_TIMER further
    // high samples are needed before link is declared.
    localparam logic [TW-1:0] RESET_TERM = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] SYNC_TERM  = TW'(SYNC_TIMEOUT - 1);
    localparam logic [TW-1:0] LINK_TERM  = TW'(LINK_TIMER);
    localparam logic [AW-1:0] RETRY_TERM = AW'(RETRY_LIMIT);

    link_state_e     state_q, state_d;
    logic [AW-1:0]   attempt_q, attempt_d;
    logic [AW-1:0]   attempt_inc;
    logic [7:0]      loss_q, loss_d;

    logic            timer_clear;
    logic            timer_enable;
    logic [TW-1:0]   timer_term;
    logic            timer_done;

    ctrl_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk      (Clk),
        .rst      (mr_main_reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_term),
        .done     (timer_done)
    );

    // attempt_q never exceeds RETRY_LIMIT-1 while WAIT_SYNC is active, so the
    // increment cannot overflow AW bits.
    assign attempt_inc = attempt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        attempt_d    = attempt_q;
        loss_d       = loss_q;
        timer_term   = '0;
        timer_enable = 1'b0;

        case (state_q)
            ST_POWER_UP: begin
                state_d = ST_PCS_RESET;
            end
            ST_PCS_RESET: begin
                timer_term   = RESET_TERM;
                timer_enable = 1'b1;
                if (timer_done) begin
                    state_d = ST_WAIT_SYNC;
                end
            end
            ST_WAIT_SYNC: begin
                timer_term   = SYNC_TERM;
                timer_enable = 1'b1;
                if (code_sync_status) begin
                    state_d = ST_CONFIRM;
                end else if (timer_done) begin
                    attempt_d = attempt_inc;
                    state_d   = (attempt_inc >= RETRY_TERM) ? ST_FAIL : ST_PCS_RESET;
                end
            end
            ST_CONFIRM: begin
                timer_term   = LINK_TERM;
                timer_enable = 1'b1;
                // A glitch during qualification is not a loss of an
                // established link, so only the state changes.
                if (!code_sync_status) begin
                    state_d = ST_WAIT_SYNC;
                end else if (timer_done) begin
                    state_d   = ST_LINK_OK;
                    attempt_d = '0;
                end
            end
            ST_LINK_OK: begin
                if (!code_sync_status) begin
                    state_d = ST_WAIT_SYNC;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_POWER_UP;
            end
        endcase

        if (mr_restart) begin
            state_d   = ST_PCS_RESET;
            attempt_d = '0;
            loss_d    = loss_q;
        end

        // Restart re-enters PCS_RESET even from PCS_RESET, so it must also
        // restart the timer.
        timer_clear = (state_d != state_q) || mr_restart;
    end

    always_ff @(posedge Clk) begin
        if (mr_main_reset) begin
            state_q   <= ST_POWER_UP;
            attempt_q <= '0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            attempt_q <= attempt_d;
            loss_q    <= loss_d;
        end
    end

    always_comb begin
        power_on   = (state_q == ST_POWER_UP);
        pcs_reset  = (state_q == ST_POWER_UP) || (state_q == ST_PCS_RESET) ||
                     (state_q == ST_FAIL);
        link_up    = (state_q == ST_LINK_OK);
        rx_enable  = (state_q == ST_LINK_OK);
        retry_fail = (state_q == ST_FAIL);
    end

    assign sync_loss_count = loss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pcs_link_controller.sv
// tb/tb_pcs_link_controller.sv - scoreboard testbench for pcs_link_controller

module tb_pcs_link_controller;

    localparam logic [2:0] S_PU   = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CONF = 3'd3;
    localparam logic [2:0] S_LINK = 3'd4;
    localparam logic [2:0] S_FAIL = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       restart;
    logic       sync;
    logic       pcs_reset;
    logic       power_on;
    logic       link_up;
    logic       rx_enable;
    logic       retry_fail;
    logic [7:0] sync_loss_count;
    logic [2:0] state;

    always #5 clk = ~clk;

    pcs_link_controller dut (
        .Clk              (clk),
        .mr_main_reset    (rst),
        .mr_restart       (restart),
        .code_sync_status (sync),
        .pcs_reset        (pcs_reset),
        .power_on         (power_on),
        .link_up          (link_up),
        .rx_enable        (rx_enable),
        .retry_fail       (retry_fail),
        .sync_loss_count  (sync_loss_count),
        .state            (state)
    );

    typedef struct {
        int          at;
        logic [15:0] vec;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc++;

    // Expected outputs of each state, straight from the output table.
    function automatic logic [15:0] mk(input logic [2:0] st, input logic [7:0] cnt);
        logic pr, po, lu, rf;
        pr = (st == S_PU) || (st == S_RST) || (st == S_FAIL);
        po = (st == S_PU);
        lu = (st == S_LINK);
        rf = (st == S_FAIL);
        return {st, pr, po, lu, lu, rf, cnt};
    endfunction

    task automatic expect_at(input int at, input logic [2:0] st, input logic [7:0] cnt,
                             input string nm);
        exp_t e;
        e.at   = at;
        e.vec  = mk(st, cnt);
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [15:0] got;
        got = {state, pcs_reset, power_on, link_up, rx_enable, retry_fail, sync_loss_count};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.at < cyc) begin
                bad++;
                $display("FAIL %s: check slot %0d missed (now %0d)", e.name, e.at, cyc);
            end else if (got !== e.vec) begin
                bad++;
                $display("FAIL %s @%0d: got {st,pr,po,lu,rx,rf,cnt}=%h required %h",
                         e.name, cyc, got, e.vec);
            end
        end
    end

    initial begin
        int b, c, f, h;
        rst     = 1'b1;
        restart = 1'b0;
        sync    = 1'b0;
        step(3);
        expect_at(cyc, S_PU, 8'd0, "reset_state");

        // Bring-up with sync asserted on WAIT_SYNC entry.
        rst = 1'b0;
        b   = cyc;
        expect_at(b + 1, S_RST,  8'd0, "pcs_reset_entry");
        expect_at(b + 4, S_RST,  8'd0, "pcs_reset_hold");
        expect_at(b + 5, S_WAIT, 8'd0, "pcs_reset_released");
        step(5);
        sync = 1'b1;
        expect_at(b + 22, S_CONF, 8'd0, "confirm_last_cycle");
        expect_at(b + 23, S_LINK, 8'd0, "link_up_after_17");
        step(18);

        // Loss while linked, then a one-cycle glitch at CONFIRM cycle 10.
        sync = 1'b0;
        expect_at(b + 24, S_WAIT, 8'd1, "first_loss");
        step(1);
        sync = 1'b1;
        c = cyc + 1;
        expect_at(c,      S_CONF, 8'd1, "confirm_reentry");
        expect_at(c + 10, S_CONF, 8'd1, "confirm_cycle10");
        expect_at(c + 11, S_WAIT, 8'd1, "glitch_back_to_wait");
        step(11);
        sync = 1'b0;
        step(1);
        sync = 1'b1;
        expect_at(c + 28, S_CONF, 8'd1, "requal_pending");
        expect_at(c + 29, S_LINK, 8'd1, "requal_link");
        step(18);

        // 300 more losses: count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            int n;
            n = (2 + i > 255) ? 255 : 2 + i;
            sync = 1'b0;
            expect_at(cyc + 1, S_WAIT, 8'(n), "loss_count");
            step(1);
            sync = 1'b1;
            expect_at(cyc + 18, S_LINK, 8'(n), "relink");
            step(18);
        end

        // Restart while linked keeps the loss count.
        restart = 1'b1;
        expect_at(cyc + 1, S_RST, 8'd255, "restart_in_link");
        step(1);
        restart = 1'b0;
        sync    = 1'b0;

        // Main reset, then sync held low until retries are exhausted.
        rst = 1'b1;
        expect_at(cyc + 1, S_PU, 8'd0, "reset_clears_count");
        step(2);
        rst = 1'b0;
        b   = cyc;
        expect_at(b + 1,   S_RST,  8'd0, "retry1_reset");
        expect_at(b + 5,   S_WAIT, 8'd0, "retry1_wait");
        expect_at(b + 68,  S_WAIT, 8'd0, "retry1_wait_last");
        expect_at(b + 69,  S_RST,  8'd0, "retry2_reset");
        expect_at(b + 73,  S_WAIT, 8'd0, "retry2_wait");
        expect_at(b + 137, S_RST,  8'd0, "retry3_reset");
        expect_at(b + 204, S_WAIT, 8'd0, "retry3_wait_last");
        expect_at(b + 205, S_FAIL, 8'd0, "retry_fail_204");
        expect_at(b + 260, S_FAIL, 8'd0, "fail_held");
        step(260);

        // Restart from FAIL clears the attempt count.
        f       = cyc;
        restart = 1'b1;
        expect_at(f + 1, S_RST, 8'd0, "restart_from_fail");
        step(1);
        restart = 1'b0;
        expect_at(f + 4,  S_RST,  8'd0, "restart_reset_hold");
        expect_at(f + 5,  S_WAIT, 8'd0, "restart_to_wait");
        expect_at(f + 68, S_WAIT, 8'd0, "after_restart_wait_last");
        expect_at(f + 69, S_RST,  8'd0, "attempts_cleared");
        step(72);
        sync = 1'b1;
        expect_at(f + 74, S_CONF, 8'd0, "confirm_before_reset");
        step(7);

        // Reset and restart together mid-CONFIRM: reset wins.
        rst     = 1'b1;
        restart = 1'b1;
        sync    = 1'b0;
        expect_at(f + 81, S_PU, 8'd0, "reset_over_restart");
        expect_at(f + 82, S_PU, 8'd0, "reset_over_restart_hold");
        step(2);

        // Restart held after reset release keeps re-entering PCS_RESET.
        rst = 1'b0;
        h   = cyc;
        expect_at(h + 1, S_RST, 8'd0, "restart_after_reset");
        expect_at(h + 6, S_RST, 8'd0, "restart_held");
        step(6);
        restart = 1'b0;
        expect_at(h + 9,  S_RST,  8'd0, "restart_release_hold");
        expect_at(h + 10, S_WAIT, 8'd0, "restart_release_wait");
        step(12);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: %0d entries left, required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
